// File: rtl/gate_bist_controller.sv
// BIST driver for combinational gate models: LFSR stimulus out, MISR response compaction in.
// Define BIST_COMPARE_EN to build the end-of-run golden-signature comparator driving pass.
module gate_bist_controller #(
    parameter int              IN_W      = 22,
    parameter int              OUT_W     = 10,
    parameter int              CNT_W     = 16,
    parameter logic [IN_W-1:0] LFSR_TAPS = 22'h300000,
    parameter logic [OUT_W-1:0] MISR_TAPS = 10'h240,
    parameter logic [IN_W-1:0] SEED      = 22'h000001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp,
    input  logic [OUT_W-1:0] expected_sig,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] signature,
    output logic             pass
);

    // state   | meaning
    // IDLE    | waiting for start, stim forced to 0
    // APPLY   | stim driven from LFSR, gate model settling
    // CAPTURE | stim held, resp folded into MISR at closing edge
    // DONE    | one-cycle done pulse, signature final
    typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

    // An all-zero seed would lock the LFSR at zero.
    localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IN_W-1:0]  lfsr;
    logic [OUT_W-1:0] misr;
    logic [IN_W-1:0]  lfsr_next;
    logic [OUT_W-1:0] misr_next;

    assign lfsr_next = {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)};
    assign misr_next = {misr[OUT_W-2:0], ^(misr & MISR_TAPS)} ^ resp;
    assign signature = misr;

`ifdef BIST_COMPARE_EN
    logic pass_q;
    assign pass = pass_q;
`else
    logic unused_expected_sig;
    assign unused_expected_sig = ^expected_sig;
    assign pass = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            lfsr  <= SEED_EFF;
            misr  <= '0;
            stim  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef BIST_COMPARE_EN
            pass_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cnt  <= num_patterns;
                        lfsr <= SEED_EFF;
                        misr <= '0;
                        if (num_patterns != '0) begin
                            state <= APPLY;
                            busy  <= 1'b1;
                            stim  <= SEED_EFF;
`ifdef BIST_COMPARE_EN
                            pass_q <= 1'b0;
`endif
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
`ifdef BIST_COMPARE_EN
                            pass_q <= (expected_sig == '0);
`endif
                        end
                    end
                end
                APPLY: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    misr <= misr_next;
                    lfsr <= lfsr_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        stim  <= '0;
`ifdef BIST_COMPARE_EN
                        // Compare against the value being written so pass is valid alongside done.
                        pass_q <= (misr_next == expected_sig);
`endif
                    end else begin
                        state <= APPLY;
                        stim  <= lfsr_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
